// File: rtl/sr2cb_m_tx_arb_if.sv
// rtl/sr2cb_m_tx_arb_if.sv - byte-stream bundle between frame sources, the TX arbiter and the PHY inserter
// Signals:
//   src_d   8*N_SRC  byte data, source i on [8*i+7:8*i]
//   src_dv  N_SRC    source frame byte valid, high for the whole frame
//   src_dr  N_SRC    arbiter ready back to each source
//   tx_d    8        byte to PHY preamble inserter
//   tx_dv   1        byte valid to PHY preamble inserter
//   tx_dr   1        PHY ready
// Modports: master = arbiter side, slave = sources plus PHY side.
interface sr2cb_m_tx_arb_if #(
    parameter int N_SRC = 2
);
    logic [8*N_SRC-1:0] src_d;
    logic [N_SRC-1:0]   src_dv;
    logic [N_SRC-1:0]   src_dr;
    logic [7:0]         tx_d;
    logic               tx_dv;
    logic               tx_dr;

    modport master (
        input  src_d, src_dv, tx_dr,
        output src_dr, tx_d, tx_dv
    );

    modport slave (
        output src_d, src_dv, tx_dr,
        input  src_dr, tx_d, tx_dv
    );
endinterface

// File: rtl/sr2cb_m_tx_arb.sv
// rtl/sr2cb_m_tx_arb.sv - frame-level arbiter sharing the master TX byte path between N frame sources
// Ports:
//   clk      clock
//   rst_n    synchronous reset, active-low
//   bus      master side of sr2cb_m_tx_arb_if (per-source src_d/src_dv/src_dr, tx_d/tx_dv/tx_dr)
//   grant    one-hot current owner, 0 when idle
//   busy     high while a frame is streaming or being flushed
//   len_err  one-cycle pulse when a frame is truncated at MAX_FRAME_BYTES
module sr2cb_m_tx_arb #(
    parameter int N_SRC           = 2,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int PRIO0           = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sr2cb_m_tx_arb_if.master  bus,
    output logic [N_SRC-1:0]  grant,
    output logic              busy,
    output logic              len_err
);
    localparam int            IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [IW:0]   N_W     = (IW+1)'(N_SRC);
    localparam logic [IW-1:0] LAST_W  = IW'(N_SRC - 1);
    localparam logic [11:0]   MAX_CNT = 12'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [11:0]       byte_cnt_q, byte_cnt_d;
    logic              len_err_q, len_err_d;

    logic [7:0]        src_byte [N_SRC];
    logic [IW-1:0]     win_idx;
    logic              win_vld;
    logic [IW:0]       cand;
    logic [IW-1:0]     rr_next;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src_byte
        assign src_byte[i] = bus.src_d[8*i +: 8];
    end

    // Round-robin search from rr_ptr. Walking offsets downwards lets the
    // smallest offset overwrite the others, so no early exit is needed.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (bus.src_dv[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
        if (PRIO0 != 0 && bus.src_dv[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
    end

    // Pointer moves past the releasing owner, even when source 0 won on priority.
    always_comb begin
        rr_next = owner_q + 1'b1;
        if (owner_q == LAST_W) begin
            rr_next = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        len_err_d  = 1'b0;
        bus.tx_d   = '0;
        bus.tx_dv  = 1'b0;
        bus.src_dr = '0;

        case (state_q)
            S_IDLE: begin
                // Arbitration cycle only; the first byte moves in the next cycle.
                if (bus.tx_dr && win_vld) begin
                    state_d          = S_STREAM;
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    byte_cnt_d       = '0;
                end
            end

            S_STREAM: begin
                if (bus.src_dv[owner_q] && byte_cnt_q == MAX_CNT) begin
                    // Frame already delivered MAX_FRAME_BYTES and is still going:
                    // swallow this byte and the rest of the frame.
                    bus.src_dr[owner_q] = 1'b1;
                    len_err_d           = 1'b1;
                    state_d             = S_FLUSH;
                end else begin
                    bus.tx_d            = src_byte[owner_q];
                    bus.tx_dv           = bus.src_dv[owner_q];
                    bus.src_dr[owner_q] = bus.tx_dr;
                    if (!bus.src_dv[owner_q]) begin
                        state_d    = S_IDLE;
                        grant_d    = '0;
                        byte_cnt_d = '0;
                        rr_ptr_d   = rr_next;
                    end else if (bus.tx_dr && byte_cnt_q != 12'hFFF) begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                end
            end

            S_FLUSH: begin
                bus.src_dr[owner_q] = 1'b1;
                if (!bus.src_dv[owner_q]) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    rr_ptr_d   = rr_next;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // Keep the byte path quiet while reset is held, even mid-frame.
        if (!rst_n) begin
            bus.tx_d   = '0;
            bus.tx_dv  = 1'b0;
            bus.src_dr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign len_err = len_err_q;
endmodule
